pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Parametrised next-generation fetch-stage PC controller for the pipelined MIPS-subset CPU.
- Holds the F-stage PC and computes the next PC for sequential flow, conditional branch, J/JAL, JR, exception entry and ERET.
- Honours pipeline stall and buffers one redirect that arrives while stalled.
- Flags fetch address errors (AdEL) for the exception unit. Sits between the D-stage control/compare logic and the instruction memory.

Parameters:
XLEN, 32, datapath/address width (>=32).
RESET_VEC, 32'h0000_3000, PC value loaded on reset.
EXC_VEC, 32'h0000_4180, exception handler entry address.
IM_BASE, 32'h0000_3000, lowest legal fetch address.
IM_WORDS, 4096, instruction memory depth in words; legal range is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
reset  in  1  synchronous active-high reset.
stall  in  1  hold F stage (hazard unit).
redir_valid  in  1  one-cycle pulse: D-stage redirect request is valid.
redir_op  in  2  0=NONE, 1=BRANCH, 2=JUMP, 3=JR.
br_taken  in  1  branch comparison result (BRANCH only).
d_pc  in  XLEN  PC of the redirecting instruction in D.
imm16  in  16  branch offset, in words, signed.
j_index  in  26  J/JAL instr_index.
jr_target  in  XLEN  forwarded rs value for JR.
exc_req  in  1  take exception (from M-stage exception unit).
eret_req  in  1  return from exception.
epc  in  XLEN  return address for ERET.
pc  out  XLEN  current fetch PC.
pc_plus4  out  XLEN  pc+4.
fetch_exc  out  1  AdEL on current fetch (misaligned or out of range).
redir_pending  out  1  a buffered redirect is waiting for stall release.

Behaviour:
- Reset: pc=RESET_VEC and redir_pending=0. fetch_exc follows pc and is therefore 0 for legal RESET_VEC. Reset mid-operation discards any pending redirect.
- Target arithmetic, all modulo 2^XLEN:
  - BRANCH target = d_pc + 4 + (sext(imm16) << 2).
  - JUMP target = {(d_pc+4)[XLEN-1:28], j_index, 2'b00}.
  - JR target = jr_target, unmodified.
- Effective request (eff_req):
  - BRANCH counts only when br_taken=1. A BRANCH with br_taken=0, or redir_op=NONE, is not a request and does not touch pending state.
  - eff_req = 1 when redir_valid=1 and the request counts.
- Next PC priority, evaluated every posedge, first match wins:
  1. reset -> RESET_VEC.
  2. exc_req -> EXC_VEC. Ignores stall; clears pending.
  3. eret_req -> epc. Ignores stall; clears pending.
  4. stall=1 -> pc holds.
     - If eff_req, latch the target into the pending register and set redir_pending=1.
     - A second eff_req while pending overwrites it (latest wins).
  5. eff_req (stall=0) -> target, directly. Clears pending; an incoming request beats a stale pending one.
  6. redir_pending=1 -> pending target; clear pending.
  7. Otherwise -> pc+4.
- Latency:
  - Redirect takes effect on the first edge with stall=0; the delay slot has already been fetched by then.
  - A redirect issued during stall appears on pc exactly one cycle after stall deasserts.
- fetch_exc (combinational from pc) = (pc[1:0]!=0) | (pc<IM_BASE) | (pc>=IM_BASE+4*IM_WORDS).
  - The PC still advances normally; downstream treats the fetched word as a NOP carrying AdEL.
  - A misaligned JR target therefore raises fetch_exc on the following cycle, not immediately.
- exc_req and eret_req together: exc_req wins.
- Wrap-around: pc+4 at 2^XLEN-4 wraps to 0, with no trap beyond fetch_exc.

Decomposition:
- Shared package cpu_pkg holds:
  - redir_op encodings (REDIR_NONE/BRANCH/JUMP/JR);
  - RESET_VEC/EXC_VEC defaults;
  - IM_BASE/IM_WORDS.
- One natural sub-module, npc_target_calc: purely combinational target selection from d_pc/imm16/j_index/jr_target.
- The top level keeps the pc register, the pending register and the priority logic.

Test Plan:
- Reset then 3 free cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; fetch_exc=0 throughout.
- Taken branch: redir_valid=1, op=BRANCH, br_taken=1, d_pc=0x3008, imm16=0xFFFE at stall=0 -> next pc=0x3004. Same with br_taken=0 -> next pc = pc+4.
- Jump during stall: stall=1 for 2 cycles with one pulse op=JUMP, d_pc=0x3010, j_index=0x0000C10 -> pc held, redir_pending=1; first cycle after stall drops -> pc=0x3040, redir_pending=0.
- Exception over pending: pending JR to 0x3100 with stall=1, then exc_req=1 -> pc=0x4180 and pending cleared; then eret_req with epc=0x3020 -> pc=0x3020.
- Address errors: JR to 0x3002 -> next pc=0x3002 with fetch_exc=1. JR to 0x7000 with IM_WORDS=4096 -> fetch_exc=1. JR to 0x6FFC -> fetch_exc=0.
- Reset asserted while redir_pending=1 -> pc=0x3000 and redir_pending=0. After reset releases, sequential fetch resumes with no stale redirect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS-subset CPU: redirect encodings and
// default memory-map constants.
package cpu_pkg;

  // D-stage redirect request kinds.
  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_JUMP   = 2'd2,
    REDIR_JR     = 2'd3
  } redir_op_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF   = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEF  = 4096;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational redirect-target selection for the fetch PC controller.
module npc_target_calc
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      redir_op,
  input  logic [XLEN-1:0] d_pc,
  input  logic [15:0]     imm16,
  input  logic [25:0]     j_index,
  input  logic [XLEN-1:0] jr_target,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] w_dpc4;
  logic [XLEN-1:0] w_br_off;

  assign w_dpc4   = d_pc + XLEN'(4);
  // Word offset, sign-extended and scaled to bytes.
  assign w_br_off = {{(XLEN-18){imm16[15]}}, imm16, 2'b00};

  // Pick the target for the requested redirect kind.
  always_comb begin
    target = w_dpc4;
    unique case (redir_op_e'(redir_op))
      REDIR_BRANCH: target = w_dpc4 + w_br_off;
      REDIR_JUMP:   target = {w_dpc4[XLEN-1:28], j_index, 2'b00};
      REDIR_JR:     target = jr_target;
      default:      target = w_dpc4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: holds the F-stage PC, applies redirects,
// exception entry and ERET, buffers one redirect across a stall and flags
// fetch address errors.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DEF),
  parameter logic [XLEN-1:0] IM_BASE   = XLEN'(IM_BASE_DEF),
  parameter int unsigned     IM_WORDS  = IM_WORDS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [1:0]      redir_op,
  input  logic            br_taken,
  input  logic [XLEN-1:0] d_pc,
  input  logic [15:0]     imm16,
  input  logic [25:0]     j_index,
  input  logic [XLEN-1:0] jr_target,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_exc,
  output logic            redir_pending
);

  // One past the last legal fetch byte; one extra bit so the sum cannot wrap.
  localparam logic [XLEN:0] ImLimit = {1'b0, IM_BASE} + (XLEN+1)'(64'(IM_WORDS) * 64'd4);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_pend;

  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pend_pc_next;
  logic            w_pend_next;
  logic [XLEN-1:0] w_target;
  logic            w_eff_req;

  npc_target_calc #(
    .XLEN (XLEN)
  ) u_npc_target_calc (
    .redir_op  (redir_op),
    .d_pc      (d_pc),
    .imm16     (imm16),
    .j_index   (j_index),
    .jr_target (jr_target),
    .target    (w_target)
  );

  assign pc_plus4      = r_pc + XLEN'(4);
  assign pc            = r_pc;
  assign redir_pending = r_pend;

  // Address error on the current fetch: misaligned or outside instruction memory.
  assign fetch_exc = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || ({1'b0, r_pc} >= ImLimit);

  // Next PC / pending-redirect selection, highest priority first.
  always_comb begin
    w_eff_req = redir_valid &&
                (((redir_op_e'(redir_op) == REDIR_BRANCH) && br_taken) ||
                 (redir_op_e'(redir_op) == REDIR_JUMP) ||
                 (redir_op_e'(redir_op) == REDIR_JR));
    w_pc_next      = pc_plus4;
    w_pend_next    = r_pend;
    w_pend_pc_next = r_pend_pc;
    if (exc_req) begin
      w_pc_next   = EXC_VEC;
      w_pend_next = 1'b0;
    end else if (eret_req) begin
      w_pc_next   = epc;
      w_pend_next = 1'b0;
    end else if (stall) begin
      w_pc_next = r_pc;
      if (w_eff_req) begin
        // Latest request while stalled overwrites any older buffered one.
        w_pend_next    = 1'b1;
        w_pend_pc_next = w_target;
      end
    end else if (w_eff_req) begin
      w_pc_next   = w_target;
      w_pend_next = 1'b0;
    end else if (r_pend) begin
      w_pc_next   = r_pend_pc;
      w_pend_next = 1'b0;
    end
  end

  // PC and pending-redirect registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_VEC;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_pc      <= w_pc_next;
      r_pend    <= w_pend_next;
      r_pend_pc <= w_pend_pc_next;
    end
  end

endmodule
